// File: rtl/glb_weight_banked_if.sv
// Write, burst-command and read-stream signals of the banked weight buffer.
// The slave modport is the buffer's view; the master modport is the driver's view.
interface glb_weight_banked_if #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int BANK_BITWIDTH = 2,
    parameter int LEN_BITWIDTH  = 11
);
    logic                     write_en;
    logic [BANK_BITWIDTH-1:0] w_bank;
    logic [ADDR_BITWIDTH-1:0] w_addr;
    logic [DATA_BITWIDTH-1:0] w_data;

    logic                     start;
    logic [BANK_BITWIDTH-1:0] r_bank;
    logic [ADDR_BITWIDTH-1:0] r_base;
    logic [LEN_BITWIDTH-1:0]  r_len;
    logic                     busy;
    logic                     done;

    logic                     r_valid;
    logic                     r_ready;
    logic [DATA_BITWIDTH-1:0] r_data;
    logic                     r_last;

    modport slave (
        input  write_en, w_bank, w_addr, w_data,
        input  start, r_bank, r_base, r_len,
        output busy, done,
        output r_valid, r_data, r_last,
        input  r_ready
    );

    modport master (
        output write_en, w_bank, w_addr, w_data,
        output start, r_bank, r_base, r_len,
        input  busy, done,
        input  r_valid, r_data, r_last,
        output r_ready
    );
endinterface

// File: rtl/glb_weight_banked.sv
// Multi-bank weight global buffer: any-time word writes plus a burst read engine
// that streams one bank through a 2-entry valid/ready output FIFO.
module glb_weight_banked #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int NUM_BANKS     = 4,
    parameter int BANK_BITWIDTH = 2,
    parameter int LEN_BITWIDTH  = 11
) (
    input logic clk,
    input logic reset,
    glb_weight_banked_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam int DEPTH = 2 ** ADDR_BITWIDTH;

    typedef logic [LEN_BITWIDTH-1:0]       len_t;
    typedef logic [2**BANK_BITWIDTH-1:0]   mask_t;

    localparam len_t  MAX_LEN   = len_t'(DEPTH);
    // One bit per encodable bank select; selects beyond NUM_BANKS are not backed by memory.
    localparam mask_t BANK_MASK = mask_t'((64'd1 << NUM_BANKS) - 64'd1);

    logic [DATA_BITWIDTH-1:0] mem [NUM_BANKS][DEPTH];

    state_t                   state;
    logic [BANK_BITWIDTH-1:0] bank_q;
    logic                     bank_ok_q;
    logic [ADDR_BITWIDTH-1:0] addr_q;
    len_t                     rem_q;
    logic                     busy_q;
    logic                     done_q;

    logic [DATA_BITWIDTH-1:0] fifo_data [2];
    logic [1:0]               fifo_last;
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               occ;

    logic                     pop;
    logic                     issue;
    logic                     is_last;
    logic [DATA_BITWIDTH-1:0] rd_word;

    assign pop     = (occ != 2'd0) && bus.r_ready;
    assign issue   = (state == ISSUE) && ((occ - {1'b0, pop}) < 2'd2);
    assign is_last = (rem_q == len_t'(1));
    assign rd_word = bank_ok_q ? mem[bank_q][addr_q] : '0;

    // Writes land at the clock edge, so a read issued in the same cycle sees the old word.
    always_ff @(posedge clk) begin
        if (reset && bus.write_en && BANK_MASK[bus.w_bank]) begin
            mem[bus.w_bank][bus.w_addr] <= bus.w_data;
        end
    end

    // The issued word is captured straight into the FIFO tail, giving the 1-cycle read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bank_q       <= '0;
            bank_ok_q    <= 1'b0;
            addr_q       <= '0;
            rem_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            occ          <= 2'd0;
        end else begin
            done_q <= 1'b0;
            if (issue) begin
                fifo_data[wr_ptr] <= rd_word;
                fifo_last[wr_ptr] <= is_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, issue} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.r_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            bank_q    <= bus.r_bank;
                            bank_ok_q <= BANK_MASK[bus.r_bank];
                            addr_q    <= bus.r_base;
                            rem_q     <= (bus.r_len > MAX_LEN) ? MAX_LEN : bus.r_len;
                            busy_q    <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr_q <= addr_q + 1'b1;
                        rem_q  <= rem_q - len_t'(1);
                        if (is_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && fifo_last[rd_ptr]) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.r_valid = (occ != 2'd0);
    assign bus.r_data  = (occ != 2'd0) ? fifo_data[rd_ptr] : '0;
    assign bus.r_last  = (occ != 2'd0) && fifo_last[rd_ptr];

endmodule

// File: tb/tb_glb_weight_banked.sv
// Directed bench for glb_weight_banked: fills banks, runs bursts under several
// ready patterns and checks every beat against hand-computed words.
module tb_glb_weight_banked;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int NB = 4;
    localparam int BW = 2;
    localparam int LW = 11;

    logic clk;
    logic reset;

    glb_weight_banked_if #(
        .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .BANK_BITWIDTH(BW), .LEN_BITWIDTH(LW)
    ) bus ();

    glb_weight_banked #(
        .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .NUM_BANKS(NB),
        .BANK_BITWIDTH(BW), .LEN_BITWIDTH(LW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    int            ready_mode;
    int            col_cycle;
    logic [BW-1:0] col_bank;
    logic [AW-1:0] col_addr;
    logic [DW-1:0] col_data;
    int            ign_cycle;

    logic [DW-1:0] got_data [$];
    logic          got_last [$];
    int            got_cyc  [$];
    logic [DW-1:0] exp_data [$];
    int            done_cyc;
    int            done_count;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [BW-1:0] bank, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data);
        bus.write_en = 1'b1;
        bus.w_bank   = bank;
        bus.w_addr   = addr;
        bus.w_data   = data;
        step();
        bus.write_en = 1'b0;
    endtask

    // One-cycle burst command; returns in the cycle after start was sampled.
    task automatic applyStimulus(input logic [BW-1:0] bank, input logic [AW-1:0] base,
                                 input logic [LW-1:0] len);
        bus.start  = 1'b1;
        bus.r_bank = bank;
        bus.r_base = base;
        bus.r_len  = len;
        step();
        bus.start  = 1'b0;
    endtask

    // Consumes beats cycle by cycle; cycle 0 is the cycle right after the start command.
    task automatic collect(input int budget);
        logic          held_v;
        logic [DW-1:0] held_d;
        held_v = 1'b0;
        held_d = '0;
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        done_cyc   = -1;
        done_count = 0;
        for (int c = 0; c < budget; c++) begin
            case (ready_mode)
                0:       bus.r_ready = 1'b1;
                1:       bus.r_ready = (c % 2 == 0);
                default: bus.r_ready = 1'($urandom_range(0, 1));
            endcase
            bus.write_en = (c == col_cycle);
            bus.w_bank   = col_bank;
            bus.w_addr   = col_addr;
            bus.w_data   = col_data;
            bus.start    = (c == ign_cycle);
            bus.r_bank   = 2'd0;
            bus.r_base   = '0;
            bus.r_len    = 11'd2;
            if (held_v) checkOutput("stall_hold", {bus.r_valid, bus.r_data}, {1'b1, held_d});
            if (bus.r_valid && bus.r_ready) begin
                got_data.push_back(bus.r_data);
                got_last.push_back(bus.r_last);
                got_cyc.push_back(c);
            end
            held_v = bus.r_valid && !bus.r_ready;
            held_d = bus.r_data;
            if (bus.done) begin
                done_count++;
                if (done_cyc < 0) done_cyc = c;
            end
            step();
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        bus.write_en = 1'b0;
        bus.start    = 1'b0;
        bus.r_ready  = 1'b1;
        col_cycle    = -1;
        ign_cycle    = -1;
        if (done_cyc < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic verify_burst(input string tag);
        int n;
        checkOutput({tag, "_count"}, got_data.size(), exp_data.size());
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_data"}, got_data[i], exp_data[i]);
            checkOutput({tag, "_last"}, got_last[i], (i == exp_data.size() - 1));
        end
        checkOutput({tag, "_done_pulses"}, done_count, 1);
        if (got_cyc.size() > 0 && done_cyc >= 0)
            checkOutput({tag, "_done_lat"}, done_cyc, got_cyc[got_cyc.size() - 1] + 1);
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            checkOutput(tag, {bus.busy, bus.done, bus.r_valid, bus.r_last, bus.r_data},
                        {3'b000, 1'b0, 16'h0000});
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: got no finish, want finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        ready_mode   = 0;
        col_cycle    = -1;
        col_bank     = '0;
        col_addr     = '0;
        col_data     = '0;
        ign_cycle    = -1;
        bus.write_en = 1'b0;
        bus.w_bank   = '0;
        bus.w_addr   = '0;
        bus.w_data   = '0;
        bus.start    = 1'b0;
        bus.r_bank   = '0;
        bus.r_base   = '0;
        bus.r_len    = '0;
        bus.r_ready  = 1'b0;
        reset        = 1'b1;
        #2 reset     = 1'b0;
        step();
        step();
        checkOutput("reset_outputs", {bus.busy, bus.done, bus.r_valid, bus.r_last, bus.r_data},
                    {3'b000, 1'b0, 16'h0000});
        reset = 1'b1;
        step();
        expect_idle("post_reset_idle", 2);

        for (int i = 0; i < 8; i++) write_word(2'd1, AW'(i), 16'h0100 + 16'(i));

        // Full-rate burst with latency and back-to-back beat checks.
        bus.r_ready = 1'b1;
        ready_mode  = 0;
        applyStimulus(2'd1, 10'h000, 11'd8);
        checkOutput("lat_first_cycle_valid", bus.r_valid, 1'b0);
        checkOutput("busy_after_start", bus.busy, 1'b1);
        collect(100);
        exp_data.delete();
        for (int i = 0; i < 8; i++) exp_data.push_back(16'h0100 + 16'(i));
        verify_burst("full");
        if (got_cyc.size() == 8) begin
            checkOutput("full_first_beat_cyc", got_cyc[0], 1);
            checkOutput("full_last_beat_cyc", got_cyc[7], 8);
        end
        checkOutput("full_done_cyc", done_cyc, 9);

        // Reset in the middle of a burst; a write during reset must be dropped.
        applyStimulus(2'd1, 10'h000, 11'd8);
        step();
        step();
        step();
        checkOutput("pre_reset_valid", bus.r_valid, 1'b1);
        reset = 1'b0;
        #1;
        checkOutput("midburst_reset_outputs",
                    {bus.busy, bus.done, bus.r_valid, bus.r_last, bus.r_data},
                    {3'b000, 1'b0, 16'h0000});
        bus.write_en = 1'b1;
        bus.w_bank   = 2'd1;
        bus.w_addr   = 10'h000;
        bus.w_data   = 16'hDEAD;
        step();
        bus.write_en = 1'b0;
        reset = 1'b1;
        step();
        expect_idle("after_abort_idle", 4);

        // Backpressure: alternating ready, then random ready.
        ready_mode = 1;
        applyStimulus(2'd1, 10'h000, 11'd8);
        collect(100);
        verify_burst("toggle");
        ready_mode = 2;
        applyStimulus(2'd1, 10'h000, 11'd8);
        collect(200);
        verify_burst("random");

        // Address wrap at the top of a bank.
        write_word(2'd0, 10'h3FE, 16'hAAA0);
        write_word(2'd0, 10'h3FF, 16'hAAA1);
        write_word(2'd0, 10'h000, 16'hAAA2);
        write_word(2'd0, 10'h001, 16'hAAA3);
        ready_mode = 0;
        applyStimulus(2'd0, 10'h3FE, 11'd4);
        collect(100);
        exp_data.delete();
        exp_data.push_back(16'hAAA0);
        exp_data.push_back(16'hAAA1);
        exp_data.push_back(16'hAAA2);
        exp_data.push_back(16'hAAA3);
        verify_burst("wrap");

        // Collision: address 2 is issued in cycle 2 at full rate; overwrite it then.
        for (int i = 0; i < 4; i++) write_word(2'd2, AW'(i), 16'h0200 + 16'(i));
        col_cycle = 2;
        col_bank  = 2'd2;
        col_addr  = 10'h002;
        col_data  = 16'hBEEF;
        applyStimulus(2'd2, 10'h000, 11'd4);
        collect(100);
        exp_data.delete();
        for (int i = 0; i < 4; i++) exp_data.push_back(16'h0200 + 16'(i));
        verify_burst("collide_old");
        applyStimulus(2'd2, 10'h000, 11'd4);
        collect(100);
        exp_data[2] = 16'hBEEF;
        verify_burst("collide_new");

        // Zero-length command: single done pulse and nothing streamed.
        applyStimulus(2'd1, 10'h000, 11'd0);
        checkOutput("len0_done", {bus.done, bus.busy, bus.r_valid}, 3'b100);
        step();
        checkOutput("len0_done_once", {bus.done, bus.busy, bus.r_valid}, 3'b000);

        // Start while busy must be ignored.
        ign_cycle = 3;
        applyStimulus(2'd1, 10'h000, 11'd8);
        collect(100);
        exp_data.delete();
        for (int i = 0; i < 8; i++) exp_data.push_back(16'h0100 + 16'(i));
        verify_burst("start_busy");
        expect_idle("start_busy_idle", 3);

        // Write to bank3 at the very address bank0 is streaming.
        col_cycle = 1;
        col_bank  = 2'd3;
        col_addr  = 10'h3FF;
        col_data  = 16'h5555;
        applyStimulus(2'd0, 10'h3FE, 11'd4);
        collect(100);
        exp_data.delete();
        exp_data.push_back(16'hAAA0);
        exp_data.push_back(16'hAAA1);
        exp_data.push_back(16'hAAA2);
        exp_data.push_back(16'hAAA3);
        verify_burst("other_bank_write");
        applyStimulus(2'd3, 10'h3FF, 11'd1);
        collect(100);
        exp_data.delete();
        exp_data.push_back(16'h5555);
        verify_burst("bank3_readback");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
